// File: rtl/grf_wr_arb_pkg.sv
// rtl/grf_wr_arb_pkg.sv - shared constants, queue entry type and helpers for the writeback arbiter
package grf_wr_arb_pkg;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_MUL = 2;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int WEN_W  = DATA_W / 8;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [WEN_W-1:0]  wen;
        logic [DATA_W-1:0] din;
    } grf_entry_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        logic [NREG-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/grf_wr_fifo.sv
// rtl/grf_wr_fifo.sv - per-requester writeback queue with pending-register summary
module grf_wr_fifo
    import grf_wr_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  grf_entry_t      i_entry,
    input  logic            i_pop,
    output grf_entry_t      o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [NREG-1:0] o_pend
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    grf_entry_t      mem_q [DEPTH];
    grf_entry_t      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   slot_off;
    logic            push_ok, pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A slot is live when its distance past the read pointer is below the count.
    always_comb begin
        o_pend   = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if (CW'(slot_off) < count_q) begin
                o_pend = o_pend | reg_onehot(mem_q[i].waddr);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/grf_wr_arb.sv
// rtl/grf_wr_arb.sv - round-robin writeback arbiter feeding a single register-file write port
module grf_wr_arb
    import grf_wr_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_en,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [ADDR_W*NREQ-1:0] i_req_waddr,
    input  logic [WEN_W*NREQ-1:0]  i_req_wen,
    input  logic [DATA_W*NREQ-1:0] i_req_din,
    output logic [NREQ-1:0]        o_req_ready,
    output logic [ADDR_W-1:0]      o_waddr,
    output logic [WEN_W-1:0]       o_wen,
    output logic [DATA_W-1:0]      o_din,
    output logic                   o_cs_b,
    output logic [NREG-1:0]        o_pend,
    output logic [NREQ-1:0]        o_grant
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] push;
    logic [NREQ-1:0] empty;
    logic [NREQ-1:0] full;
    logic [NREQ-1:0] grant;
    grf_entry_t      head   [NREQ];
    logic [NREG-1:0] q_pend [NREQ];
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [GW-1:0]   sel;
    logic            found;
    logic            issue;
    int              rr_idx;

    for (genvar n = 0; n < NREQ; n++) begin : g_req
        grf_entry_t req_entry;

        assign req_entry = {i_req_waddr[ADDR_W*n +: ADDR_W],
                            i_req_wen[WEN_W*n +: WEN_W],
                            i_req_din[DATA_W*n +: DATA_W]};
        // Ready comes from the registered count only, so a full queue never takes a pop-through push.
        assign push[n]   = i_req_valid[n] & ~full[n] & i_clk_en;

        grf_wr_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (push[n]),
            .i_entry (req_entry),
            .i_pop   (grant[n]),
            .o_head  (head[n]),
            .o_full  (full[n]),
            .o_empty (empty[n]),
            .o_pend  (q_pend[n])
        );
    end

    assign o_req_ready = ~full;
    assign o_grant     = grant;

    always_comb begin
        found  = 1'b0;
        sel    = last_grant_q;
        rr_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(last_grant_q) + k) % NREQ;
            if (!found && !empty[GW'(rr_idx)]) begin
                found = 1'b1;
                sel   = GW'(rr_idx);
            end
        end
    end

    assign issue = found & i_clk_en;

    always_comb begin
        grant        = '0;
        o_cs_b       = 1'b1;
        o_waddr      = '0;
        o_wen        = '0;
        o_din        = '0;
        last_grant_d = last_grant_q;
        if (issue) begin
            grant[sel]   = 1'b1;
            o_cs_b       = 1'b0;
            o_waddr      = head[sel].waddr;
            o_wen        = head[sel].wen;
            o_din        = head[sel].din;
            last_grant_d = sel;
        end
    end

    always_comb begin
        o_pend = '0;
        for (int n = 0; n < NREQ; n++) begin
            o_pend = o_pend | q_pend[n];
        end
    end

    // Resetting to the last requester makes requester 0 the first one searched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_q <= GW'(NREQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_grf_wr_arb.sv
// tb/tb_grf_wr_arb.sv - scoreboard bench for the writeback arbiter
module tb_grf_wr_arb;
    import grf_wr_arb_pkg::*;

    localparam int NREQ = 3;

    logic        i_clk       = 1'b0;
    logic        i_rst       = 1'b1;
    logic        i_clk_en    = 1'b1;
    logic [2:0]  i_req_valid = '0;
    logic [11:0] i_req_waddr = '0;
    logic [11:0] i_req_wen   = '0;
    logic [95:0] i_req_din   = '0;
    logic [2:0]  o_req_ready;
    logic [3:0]  o_waddr;
    logic [3:0]  o_wen;
    logic [31:0] o_din;
    logic        o_cs_b;
    logic [15:0] o_pend;
    logic [2:0]  o_grant;

    typedef struct packed {
        logic [3:0]  waddr;
        logic [3:0]  wen;
        logic [31:0] din;
        logic [2:0]  grant;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] rf [16] = '{default: 32'h0};
    int          total = 0;
    int          bad   = 0;

    grf_wr_arb #(
        .NREQ  (NREQ),
        .DEPTH (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clk_en    (i_clk_en),
        .i_req_valid (i_req_valid),
        .i_req_waddr (i_req_waddr),
        .i_req_wen   (i_req_wen),
        .i_req_din   (i_req_din),
        .o_req_ready (o_req_ready),
        .o_waddr     (o_waddr),
        .o_wen       (o_wen),
        .o_din       (o_din),
        .o_cs_b      (o_cs_b),
        .o_pend      (o_pend),
        .o_grant     (o_grant)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
        i_req_valid[n]       = 1'b1;
        i_req_waddr[4*n +: 4] = a;
        i_req_wen[4*n +: 4]   = w;
        i_req_din[32*n +: 32] = d;
    endtask

    task automatic clr_req();
        i_req_valid = '0;
    endtask

    task automatic expect_wr(input int n, input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
        exp_t e;
        e.waddr = a;
        e.wen   = w;
        e.din   = d;
        e.grant = 3'(1 << n);
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (o_cs_b === 1'b0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h wen=%0h din=%0h grant=%0b expected no write",
                         o_waddr, o_wen, o_din, o_grant);
            end else begin
                e = sb.pop_front();
                chk("wr_grant", 64'(o_grant), 64'(e.grant));
                chk("wr_waddr", 64'(o_waddr), 64'(e.waddr));
                chk("wr_wen", 64'(o_wen), 64'(e.wen));
                chk("wr_din", 64'(o_din), 64'(e.din));
            end
            for (int b = 0; b < 4; b++) begin
                if (o_wen[b]) rf[o_waddr][8*b +: 8] = o_din[8*b +: 8];
            end
        end else begin
            chk("idle_zero", 64'({o_grant, o_waddr, o_wen, o_din}), 64'(0));
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_ready", 64'(o_req_ready), 64'(3'b111));
        chk("rst_cs_b", 64'(o_cs_b), 64'(1));
        chk("rst_grant", 64'(o_grant), 64'(0));
        chk("rst_pend", 64'(o_pend), 64'(0));
        chk("rst_data", 64'({o_waddr, o_wen, o_din}), 64'(0));
        i_rst = 1'b0;
        tick();

        // single uncontended write
        set_req(REQ_ALU, 4'd5, 4'hF, 32'h12345678);
        expect_wr(REQ_ALU, 4'd5, 4'hF, 32'h12345678);
        tick();
        clr_req();
        chk("t1_cs_b", 64'(o_cs_b), 64'(0));
        chk("t1_pend", 64'(o_pend), 64'(16'h0020));
        chk("t1_grant", 64'(o_grant), 64'(3'b001));
        tick();
        chk("t1_pend_clr", 64'(o_pend), 64'(0));
        chk("t1_idle", 64'(o_cs_b), 64'(1));

        // contention from reset, then rotation from last=MUL
        reset_dut();
        set_req(REQ_ALU, 4'd1, 4'hF, 32'h11);
        set_req(REQ_MEM, 4'd2, 4'hF, 32'h22);
        set_req(REQ_MUL, 4'd3, 4'hF, 32'h33);
        expect_wr(REQ_ALU, 4'd1, 4'hF, 32'h11);
        expect_wr(REQ_MEM, 4'd2, 4'hF, 32'h22);
        expect_wr(REQ_MUL, 4'd3, 4'hF, 32'h33);
        tick();
        clr_req();
        chk("t2_g0", 64'(o_grant), 64'(3'b001));
        chk("t2_pend", 64'(o_pend), 64'(16'h000E));
        tick();
        chk("t2_g1", 64'(o_grant), 64'(3'b010));
        tick();
        chk("t2_g2", 64'(o_grant), 64'(3'b100));
        tick();
        chk("t2_idle", 64'(o_cs_b), 64'(1));
        set_req(REQ_ALU, 4'd4, 4'hF, 32'h44);
        set_req(REQ_MUL, 4'd6, 4'hF, 32'h66);
        expect_wr(REQ_ALU, 4'd4, 4'hF, 32'h44);
        expect_wr(REQ_MUL, 4'd6, 4'hF, 32'h66);
        tick();
        clr_req();
        chk("t2_rot_alu", 64'(o_grant), 64'(3'b001));
        tick();
        chk("t2_rot_mul", 64'(o_grant), 64'(3'b100));
        tick();

        // MEM fills to two entries; a third push while full is refused
        set_req(REQ_ALU, 4'd10, 4'hF, 32'hA0);
        set_req(REQ_MEM, 4'd11, 4'hF, 32'hB1);
        set_req(REQ_MUL, 4'd12, 4'hF, 32'hC2);
        expect_wr(REQ_ALU, 4'd10, 4'hF, 32'hA0);
        expect_wr(REQ_MEM, 4'd11, 4'hF, 32'hB1);
        expect_wr(REQ_MUL, 4'd12, 4'hF, 32'hC2);
        expect_wr(REQ_MEM, 4'd13, 4'hF, 32'hB2);
        tick();
        clr_req();
        set_req(REQ_MEM, 4'd13, 4'hF, 32'hB2);
        chk("t3_ready_a", 64'(o_req_ready), 64'(3'b111));
        chk("t3_grant_a", 64'(o_grant), 64'(3'b001));
        tick();
        set_req(REQ_MEM, 4'd14, 4'hF, 32'hDEAD);
        chk("t3_ready_full", 64'(o_req_ready), 64'(3'b101));
        chk("t3_pend_full", 64'(o_pend), 64'(16'h3800));
        chk("t3_grant_b", 64'(o_grant), 64'(3'b010));
        tick();
        clr_req();
        chk("t3_ready_c", 64'(o_req_ready), 64'(3'b111));
        chk("t3_pend_c", 64'(o_pend), 64'(16'h3000));
        chk("t3_grant_c", 64'(o_grant), 64'(3'b100));
        tick();
        chk("t3_grant_d", 64'(o_grant), 64'(3'b010));
        tick();
        chk("t3_idle", 64'(o_cs_b), 64'(1));

        // clock enable low freezes the queue and blocks pushes
        set_req(REQ_ALU, 4'd2, 4'hF, 32'h5);
        expect_wr(REQ_ALU, 4'd2, 4'hF, 32'h5);
        tick();
        i_clk_en = 1'b0;
        clr_req();
        set_req(REQ_MUL, 4'd3, 4'hF, 32'h77);
        #1;
        chk("t4_frz_cs_b", 64'(o_cs_b), 64'(1));
        chk("t4_frz_grant", 64'(o_grant), 64'(0));
        chk("t4_frz_pend", 64'(o_pend), 64'(16'h0004));
        tick();
        tick();
        chk("t4_frz_hold", 64'(o_pend), 64'(16'h0004));
        chk("t4_frz_ready", 64'(o_req_ready), 64'(3'b111));
        clr_req();
        i_clk_en = 1'b1;
        #1;
        chk("t4_resume", 64'(o_grant), 64'(3'b001));
        tick();
        chk("t4_idle", 64'(o_cs_b), 64'(1));

        // same-register writes from one requester stay in order
        set_req(REQ_MUL, 4'd7, 4'hF, 32'hA);
        expect_wr(REQ_MUL, 4'd7, 4'hF, 32'hA);
        expect_wr(REQ_MUL, 4'd7, 4'hF, 32'hB);
        tick();
        set_req(REQ_MUL, 4'd7, 4'hF, 32'hB);
        chk("t5_pend_a", 64'(o_pend[7]), 64'(1));
        tick();
        clr_req();
        chk("t5_pend_b", 64'(o_pend[7]), 64'(1));
        chk("t5_grant", 64'(o_grant), 64'(3'b100));
        tick();
        chk("t5_pend_clr", 64'(o_pend), 64'(0));
        chk("t5_rf7", 64'(rf[7]), 64'(32'hB));

        // partial byte write, then a no-byte write that still takes a slot
        set_req(REQ_ALU, 4'd9, 4'b0100, 32'h00AB0000);
        expect_wr(REQ_ALU, 4'd9, 4'b0100, 32'h00AB0000);
        tick();
        clr_req();
        chk("t6_wen", 64'(o_wen), 64'(4'b0100));
        chk("t6_waddr", 64'(o_waddr), 64'(9));
        tick();
        chk("t6_wen_clr", 64'(o_wen), 64'(0));
        chk("t6_rf9", 64'(rf[9]), 64'(32'h00AB0000));
        set_req(REQ_ALU, 4'd3, 4'b0000, 32'hFFFFFFFF);
        expect_wr(REQ_ALU, 4'd3, 4'b0000, 32'hFFFFFFFF);
        tick();
        clr_req();
        chk("t7_pend", 64'(o_pend), 64'(16'h0008));
        chk("t7_cs_b", 64'(o_cs_b), 64'(0));
        tick();
        chk("t7_rf3", 64'(rf[3]), 64'(32'h33));

        // reset with two entries queued discards them
        set_req(REQ_ALU, 4'd1, 4'hF, 32'hBAD1);
        set_req(REQ_MEM, 4'd2, 4'hF, 32'hBAD2);
        tick();
        clr_req();
        chk("t8_pend_pre", 64'(o_pend), 64'(16'h0006));
        chk("t8_cs_pre", 64'(o_cs_b), 64'(0));
        #1;
        i_rst = 1'b1;
        #1;
        chk("t8_cs_b", 64'(o_cs_b), 64'(1));
        chk("t8_pend", 64'(o_pend), 64'(0));
        chk("t8_ready", 64'(o_req_ready), 64'(3'b111));
        chk("t8_grant", 64'(o_grant), 64'(0));
        tick();
        tick();
        i_rst = 1'b0;
        repeat (3) tick();
        chk("t8_no_write", 64'(o_cs_b), 64'(1));

        chk("sb_drain", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
